io_periph: RTL and testbench

IO_PERIPH -- requirements
Module: io_periph

---
 rtl/io_pkg.sv | 34 +++
 rtl/btn_debounce.sv | 67 ++++++
 rtl/io_periph.sv | 155 +++++++++++++++
 tb/tb_io_periph.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared constants, types and helpers for the IO peripheral window.
package io_pkg;

  // Byte offsets of the registers inside the 256-byte IO window.
  localparam logic [7:0] OFF_LEDR   = 8'h00;
  localparam logic [7:0] OFF_LEDG   = 8'h04;
  localparam logic [7:0] OFF_HEX_LO = 8'h08;
  localparam logic [7:0] OFF_HEX_HI = 8'h0C;
  localparam logic [7:0] OFF_SW     = 8'h10;
  localparam logic [7:0] OFF_BTN    = 8'h14;
  localparam logic [7:0] OFF_EDGE   = 8'h18;

  // Board resource widths.
  localparam int LEDR_W     = 18;
  localparam int LEDG_W     = 9;
  localparam int HEX_W      = 7;
  localparam int HEX_DIGITS = 8;
  localparam int SW_W       = 18;
  localparam int BTN_N      = 4;

  // Stable-sample count needed to accept a button change (about 1 ms at 50 MHz).
  localparam int DEBOUNCE_DEFAULT = 50000;

  typedef enum logic {
    DB_RELEASED = 1'b0,
    DB_PRESSED  = 1'b1
  } db_state_e;

  // Four 7-bit digits into one bus word, one digit per byte, bit 7 of each byte zero.
  function automatic logic [31:0] pack_hex4(input logic [4*HEX_W-1:0] d);
    return {1'b0, d[27:21], 1'b0, d[20:14], 1'b0, d[13:7], 1'b0, d[6:0]};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: synchronizer, RELEASED/PRESSED debounce FSM and stability counter.
module btn_debounce
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic             sample;
  db_state_e        state;
  db_state_e        state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Synchronize the pressed level (pin is active-low, so a cleared flop means released).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sample <= 1'b0;
    end else begin
      meta   <= ~btn_n;
      sample <= meta;
    end
  end

  // Debounce state and stability counter; reset drops any partial count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DB_RELEASED;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Count samples that disagree with the accepted state; flip on the last one in a row.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    press      = 1'b0;
    if (sample != (state == DB_PRESSED)) begin
      if (cnt == CNT_LAST) begin
        if (state == DB_RELEASED) begin
          state_next = DB_PRESSED;
          press      = 1'b1;
        end else begin
          state_next = DB_RELEASED;
        end
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  assign level = (state == DB_PRESSED);

endmodule

// File: rtl/io_periph.sv
// Memory-mapped board IO: LED/HEX registers, switch and debounced button inputs.
module io_periph
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_io_en,
  input  logic        i_io_wren,
  input  logic [7:0]  i_io_addr,
  input  logic [3:0]  i_bmask,
  input  logic [31:0] i_data_io,
  input  logic [17:0] i_sw,
  input  logic [3:0]  i_btn,
  output logic [31:0] o_io_rdata,
  output logic [17:0] o_ledr,
  output logic [8:0]  o_ledg,
  output logic [55:0] o_hex
);

  logic [LEDR_W-1:0]           ledr_reg, ledr_next;
  logic [LEDG_W-1:0]           ledg_reg, ledg_next;
  logic [HEX_DIGITS*HEX_W-1:0] hex_bus;
  logic [BTN_N-1:0]            edge_reg, edge_next;
  logic [BTN_N-1:0]            btn_level, btn_press;
  logic [SW_W-1:0]             sw_meta, sw_sync;
  logic [31:0]                 rdata_reg, rdata_next;
  logic [5:0]                  word;
  logic                        wr_en;
  logic                        wr_ledr, wr_ledg, wr_hex_lo, wr_hex_hi, wr_edge;
  logic                        unused_bits;

  // Byte-offset bits and the bit-7 slots of the upper HEX bytes carry no state.
  assign unused_bits = ^{i_io_addr[1:0], i_data_io[31], i_data_io[23]};

  assign word      = i_io_addr[7:2];
  assign wr_en     = i_io_en & i_io_wren;
  assign wr_ledr   = wr_en && (word == OFF_LEDR[7:2]);
  assign wr_ledg   = wr_en && (word == OFF_LEDG[7:2]);
  assign wr_hex_lo = wr_en && (word == OFF_HEX_LO[7:2]);
  assign wr_hex_hi = wr_en && (word == OFF_HEX_HI[7:2]);
  assign wr_edge   = wr_en && (word == OFF_EDGE[7:2]);

  // Byte-lane merge for the LED registers, one bit at a time.
  for (genvar gi = 0; gi < LEDR_W; gi++) begin : g_ledr_bit
    assign ledr_next[gi] = (wr_ledr && i_bmask[gi/8]) ? i_data_io[gi] : ledr_reg[gi];
  end
  for (genvar gi = 0; gi < LEDG_W; gi++) begin : g_ledg_bit
    assign ledg_next[gi] = (wr_ledg && i_bmask[gi/8]) ? i_data_io[gi] : ledg_reg[gi];
  end

  // LED registers drive the pins directly.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ledr_reg <= '0;
      ledg_reg <= '0;
    end else begin
      ledr_reg <= ledr_next;
      ledg_reg <= ledg_next;
    end
  end

  // One register per seven-segment digit; digits 0..3 live in the low word, 4..7 in the high.
  for (genvar gi = 0; gi < HEX_DIGITS; gi++) begin : g_hex
    logic             wr_digit;
    logic [HEX_W-1:0] digit_reg;

    assign wr_digit = ((gi < 4) ? wr_hex_lo : wr_hex_hi) && i_bmask[gi % 4];

    // Digit store: only the seven segment bits of its byte lane are kept.
    always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
        digit_reg <= '0;
      end else if (wr_digit) begin
        digit_reg <= i_data_io[8*(gi % 4) +: HEX_W];
      end
    end

    assign hex_bus[HEX_W*gi +: HEX_W] = digit_reg;
  end

  // Two-flop synchronizer for the slide switches.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= i_sw;
      sw_sync <= sw_meta;
    end
  end

  for (genvar gi = 0; gi < BTN_N; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (i_clk),
      .rst_n(i_reset),
      .btn_n(i_btn[gi]),
      .level(btn_level[gi]),
      .press(btn_press[gi])
    );
  end

  // Sticky press flags: write-one-to-clear, but a press in the same cycle wins.
  always_comb begin
    edge_next = edge_reg;
    if (wr_edge && i_bmask[0]) begin
      edge_next = edge_reg & ~i_data_io[BTN_N-1:0];
    end
    edge_next = edge_next | btn_press;
  end

  // Edge flag register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      edge_reg <= '0;
    end else begin
      edge_reg <= edge_next;
    end
  end

  // Read mux samples the current (pre-write) register values; holds when not selected.
  always_comb begin
    rdata_next = rdata_reg;
    if (i_io_en) begin
      case (word)
        OFF_LEDR[7:2]:   rdata_next = 32'(ledr_reg);
        OFF_LEDG[7:2]:   rdata_next = 32'(ledg_reg);
        OFF_HEX_LO[7:2]: rdata_next = pack_hex4(hex_bus[4*HEX_W-1:0]);
        OFF_HEX_HI[7:2]: rdata_next = pack_hex4(hex_bus[8*HEX_W-1:4*HEX_W]);
        OFF_SW[7:2]:     rdata_next = 32'(sw_sync);
        OFF_BTN[7:2]:    rdata_next = 32'(btn_level);
        OFF_EDGE[7:2]:   rdata_next = 32'(edge_reg);
        default:         rdata_next = '0;
      endcase
    end
  end

  // Registered read data, one cycle after the access.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rdata_reg <= '0;
    end else begin
      rdata_reg <= rdata_next;
    end
  end

  assign o_io_rdata = rdata_reg;
  assign o_ledr     = ledr_reg;
  assign o_ledg     = ledg_reg;
  assign o_hex      = hex_bus;

endmodule

// File: tb/tb_io_periph.sv
// Randomized bench for io_periph with a register-map reference model and a read scoreboard.
module tb_io_periph;
  import io_pkg::*;

  localparam int DB = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        en    = 1'b0;
  logic        wren  = 1'b0;
  logic [7:0]  addr  = '0;
  logic [3:0]  bmask = '0;
  logic [31:0] data  = '0;
  logic [17:0] sw    = 18'h2A5A5;
  logic [3:0]  btn   = 4'hF;
  logic [31:0] rdata;
  logic [17:0] ledr;
  logic [8:0]  ledg;
  logic [55:0] hex;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  io_periph #(.DEBOUNCE_CYCLES(DB)) dut (
    .i_clk     (clk),
    .i_reset   (rst_n),
    .i_io_en   (en),
    .i_io_wren (wren),
    .i_io_addr (addr),
    .i_bmask   (bmask),
    .i_data_io (data),
    .i_sw      (sw),
    .i_btn     (btn),
    .o_io_rdata(rdata),
    .o_ledr    (ledr),
    .o_ledg    (ledg),
    .o_hex     (hex)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [17:0] m_ledr = '0;
  logic [8:0]  m_ledg = '0;
  logic [6:0]  m_hex [8];
  logic [3:0]  m_edge = '0;
  logic [3:0]  m_lvl  = '0;
  logic [3:0]  pb_h1  = '0;   // pressed level seen one edge ago
  logic [3:0]  pb_h2  = '0;   // pressed level seen two edges ago
  logic [17:0] sw_h1  = '0;
  logic [17:0] sw_h2  = '0;
  int          m_run [4];
  logic [31:0] exp_q [$];
  logic [31:0] mw;
  logic [3:0]  mclr, mset;

  function automatic logic [31:0] model_read(input logic [7:0] a);
    logic [31:0] v;
    int base;
    v = '0;
    case (a & 8'hFC)
      8'h00: v = 32'(m_ledr);
      8'h04: v = 32'(m_ledg);
      8'h08, 8'h0C: begin
        base = ((a & 8'hFC) == 8'h08) ? 0 : 4;
        for (int k = 0; k < 4; k++) v[8*k +: 7] = m_hex[base+k];
      end
      8'h10: v = 32'(sw_h2);
      8'h14: v = 32'(m_lvl);
      8'h18: v = 32'(m_edge);
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [55:0] model_hex();
    logic [55:0] h;
    for (int k = 0; k < 8; k++) h[7*k +: 7] = m_hex[k];
    return h;
  endfunction

  initial begin
    for (int k = 0; k < 8; k++) m_hex[k] = '0;
    for (int k = 0; k < 4; k++) m_run[k] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_ledr = '0; m_ledg = '0; m_edge = '0; m_lvl = '0;
        pb_h1 = '0; pb_h2 = '0; sw_h1 = '0; sw_h2 = '0;
        for (int k = 0; k < 8; k++) m_hex[k] = '0;
        for (int k = 0; k < 4; k++) m_run[k] = 0;
        exp_q.delete();
      end else begin
        if (en) exp_q.push_back(model_read(addr));
        mclr = '0;
        if (en && wren) begin
          case (addr & 8'hFC)
            8'h00: begin
              mw = 32'(m_ledr);
              for (int k = 0; k < 4; k++) if (bmask[k]) mw[8*k +: 8] = data[8*k +: 8];
              m_ledr = mw[17:0];
            end
            8'h04: begin
              mw = 32'(m_ledg);
              for (int k = 0; k < 4; k++) if (bmask[k]) mw[8*k +: 8] = data[8*k +: 8];
              m_ledg = mw[8:0];
            end
            8'h08: for (int k = 0; k < 4; k++) if (bmask[k]) m_hex[k]   = data[8*k +: 7];
            8'h0C: for (int k = 0; k < 4; k++) if (bmask[k]) m_hex[k+4] = data[8*k +: 7];
            8'h18: if (bmask[0]) mclr = data[3:0];
            default: ;
          endcase
        end
        // A button flips after DB consecutive synchronized samples differ from its state.
        mset = '0;
        for (int b = 0; b < 4; b++) begin
          if (pb_h2[b] != m_lvl[b]) begin
            m_run[b]++;
            if (m_run[b] == DB) begin
              m_lvl[b] = pb_h2[b];
              m_run[b] = 0;
              if (pb_h2[b]) mset[b] = 1'b1;
            end
          end else begin
            m_run[b] = 0;
          end
        end
        m_edge = (m_edge & ~mclr) | mset;
        pb_h2 = pb_h1; pb_h1 = ~btn;
        sw_h2 = sw_h1; sw_h1 = sw;
      end
    end
  end

  // ---------------- monitor ----------------
  logic        pend     = 1'b0;
  logic [31:0] last_exp = '0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pend     = 1'b0;
        last_exp = '0;
      end else begin
        pend = en;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (pend) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL rdata_queue: got read response, expected none queued at %0t", $time);
        end else begin
          last_exp = exp_q.pop_front();
        end
      end
      chk("rdata", 64'(rdata), 64'(last_exp));
      chk("ledr",  64'(ledr),  64'(m_ledr));
      chk("ledg",  64'(ledg),  64'(m_ledg));
      chk("hex",   64'(hex),   64'(model_hex()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    @(posedge clk); #1;
    en = 1'b0; wren = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [3:0] m, input logic [31:0] d);
    @(posedge clk); #1;
    en = 1'b1; wren = 1'b1; addr = a; bmask = m; data = d;
  endtask

  task automatic rd(input logic [7:0] a);
    @(posedge clk); #1;
    en = 1'b1; wren = 1'b0; addr = a; bmask = 4'hF; data = $urandom;
  endtask

  logic [7:0] addr_tab [8];

  initial begin
    addr_tab = '{OFF_LEDR, OFF_LEDG, OFF_HEX_LO, OFF_HEX_HI, OFF_SW, OFF_BTN, OFF_EDGE, 8'h40};

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("reset_rdata", 64'(rdata), 64'h0);
    chk("reset_hex",   64'(hex),   64'h0);
    rst_n = 1'b1;
    idle();

    // Full-width LEDR write, then readback.
    wr(OFF_LEDR, 4'hF, 32'h0003FFFF);
    rd(OFF_LEDR);
    chk("ledr_full", 64'(ledr), 64'h3FFFF);
    idle();
    chk("ledr_read", 64'(rdata), 64'h0003FFFF);

    // Single byte lane into the low HEX word.
    wr(OFF_HEX_LO, 4'b0010, 32'hFFFFFFFF);
    rd(OFF_HEX_LO);
    chk("hex1_only", 64'(hex), 64'h3F80);
    idle();
    chk("hex_lo_read", 64'(rdata), 64'h00007F00);

    wr(OFF_LEDG, 4'b0011, 32'hFFFFFFFF);
    wr(OFF_HEX_HI, 4'b1001, 32'h12345678);
    rd(OFF_LEDG);
    rd(OFF_HEX_HI);
    rd(OFF_SW);

    // Read-only and unmapped writes are dropped.
    wr(OFF_SW, 4'hF, 32'hFFFFFFFF);
    wr(8'h40, 4'hF, 32'hFFFFFFFF);
    rd(8'h40);
    rd(OFF_SW);
    chk("unmapped_read", 64'(rdata), 64'h0);
    idle();

    // A 3-sample press is a bounce; an 8-sample press is accepted.
    btn[0] = 1'b0;
    repeat (3) idle();
    btn[0] = 1'b1;
    repeat (6) idle();
    rd(OFF_BTN); rd(OFF_EDGE);
    chk("bounce_btn", 64'(rdata), 64'h0);
    idle();
    chk("bounce_edge", 64'(rdata), 64'h0);
    btn[0] = 1'b0;
    repeat (8) idle();
    rd(OFF_BTN); rd(OFF_EDGE);
    chk("press_btn", 64'(rdata), 64'h1);
    idle();
    chk("press_edge", 64'(rdata), 64'h1);

    // Release, then press again so the acceptance coincides with a W1C of the same bit.
    btn[0] = 1'b1;
    repeat (8) idle();
    btn[0] = 1'b0;
    repeat (4) idle();
    wr(OFF_EDGE, 4'h1, 32'h1);
    rd(OFF_EDGE);
    idle();
    chk("set_beats_clear", 64'(rdata), 64'h1);
    wr(OFF_EDGE, 4'h1, 32'h1);
    rd(OFF_EDGE);
    idle();
    chk("w1c_clear", 64'(rdata), 64'h0);
    btn[0] = 1'b1;

    // Random traffic with slowly changing buttons.
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      en    = ($urandom_range(0, 9) < 7);
      wren  = 1'($urandom_range(0, 1));
      addr  = addr_tab[$urandom_range(0, 7)] | 8'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) addr = 8'($urandom);
      bmask = 4'($urandom);
      data  = $urandom;
      if ($urandom_range(0, 7) == 0) sw = 18'($urandom);
      if ($urandom_range(0, 5) == 0) btn[$urandom_range(0, 3)] ^= 1'b1;
    end
    idle();
    btn = 4'hF;
    repeat (8) idle();

    // Reset in the middle of a debounce count with LEDs lit.
    wr(OFF_LEDR, 4'hF, 32'h000155AA);
    wr(OFF_LEDG, 4'hF, 32'h000001FF);
    wr(OFF_HEX_HI, 4'hF, 32'h7F7F7F7F);
    rd(OFF_LEDG);
    idle();
    btn[1] = 1'b0;
    repeat (3) idle();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ledr",  64'(ledr),  64'h0);
    chk("async_rst_ledg",  64'(ledg),  64'h0);
    chk("async_rst_hex",   64'(hex),   64'h0);
    chk("async_rst_rdata", 64'(rdata), 64'h0);
    btn[1] = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (12) idle();
    rd(OFF_EDGE); rd(OFF_BTN);
    chk("edge_after_rst", 64'(rdata), 64'h0);
    idle();
    chk("btn_after_rst", 64'(rdata), 64'h0);
    wr(OFF_LEDR, 4'h1, 32'hFFFFFFAB);
    rd(OFF_LEDR);
    chk("first_write", 64'(ledr), 64'hAB);
    idle();

    for (int k = 0; k < 8; k++) rd(addr_tab[k]);
    repeat (3) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion before 200000");
    $fatal(1, "timeout");
  end

endmodule
